// File: rtl/vlc_4b6b_rx_if.sv
// Bit-stream input and decoded-frame output bundle for the 4B6B receiver.
interface vlc_4b6b_rx_if;
  logic       bit_valid;
  logic       bit_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_start;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       sym_err;
  logic       busy;

  modport master (
    output bit_valid, bit_in,
    input  data_out, data_valid, frame_start, frame_len, frame_done, sym_err, busy
  );

  modport slave (
    input  bit_valid, bit_in,
    output data_out, data_valid, frame_start, frame_len, frame_done, sym_err, busy
  );
endinterface

// File: rtl/vlc_4b6b_rx.sv
// VLC 4B6B receive framer: SFD hunt, 6-bit symbol decode, nibble pairing,
// length-prefixed payload output with bit-gap timeout.
module vlc_4b6b_rx #(
  parameter int unsigned       SFD_W   = 12,
  parameter logic [SFD_W-1:0]  SFD     = 12'b111000111000,
  parameter int unsigned       TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  vlc_4b6b_rx_if.slave       bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {HUNT, LEN, DATA} state_t;

  state_t           state_q, state_d;
  // Only the older bits are stored; the newest bit is bit_in itself.
  logic [SFD_W-2:0] sfd_q, sfd_d;
  logic [4:0]       sym_q, sym_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic             half_q, half_d;
  logic [3:0]       hi_q, hi_d;
  logic [7:0]       rem_q, rem_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       len_q, len_d;
  logic             dv_q, dv_d, fs_q, fs_d, fd_q, fd_d, se_q, se_d;

  logic [SFD_W-1:0] sfd_full;
  logic [5:0]       sym_full;
  logic [4:0]       dec;
  logic [7:0]       pair_byte;

  // Returns {valid, nibble} for a received codeword.
  function automatic logic [4:0] decode(input logic [5:0] cw);
    case (cw)
      6'b001110: decode = 5'h10;
      6'b001101: decode = 5'h11;
      6'b010011: decode = 5'h12;
      6'b010110: decode = 5'h13;
      6'b010101: decode = 5'h14;
      6'b100011: decode = 5'h15;
      6'b100110: decode = 5'h16;
      6'b100101: decode = 5'h17;
      6'b011001: decode = 5'h18;
      6'b011010: decode = 5'h19;
      6'b011100: decode = 5'h1A;
      6'b110001: decode = 5'h1B;
      6'b110010: decode = 5'h1C;
      6'b101001: decode = 5'h1D;
      6'b101010: decode = 5'h1E;
      6'b101100: decode = 5'h1F;
      default:   decode = 5'h00;
    endcase
  endfunction

  // Next-state and next-output logic; every pulse is prepared here and
  // registered, so it appears one clock after the completing bit.
  always_comb begin
    state_d   = state_q;
    sfd_d     = sfd_q;
    sym_d     = sym_q;
    bcnt_d    = bcnt_q;
    half_d    = half_q;
    hi_d      = hi_q;
    rem_d     = rem_q;
    tmo_d     = tmo_q;
    dout_d    = dout_q;
    len_d     = len_q;
    dv_d      = 1'b0;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    se_d      = 1'b0;
    sfd_full  = {sfd_q, bus.bit_in};
    sym_full  = {sym_q, bus.bit_in};
    dec       = decode(sym_full);
    pair_byte = {hi_q, dec[3:0]};

    case (state_q)
      HUNT: begin
        tmo_d  = '0;
        bcnt_d = '0;
        half_d = 1'b0;
        if (bus.bit_valid) begin
          sfd_d = sfd_full[SFD_W-2:0];
          if (sfd_full == SFD) begin
            fs_d    = 1'b1;
            state_d = LEN;
          end
        end
      end
      LEN, DATA: begin
        if (bus.bit_valid) begin
          tmo_d = '0;
          sym_d = sym_full[4:0];
          if (bcnt_q == 3'd5) begin
            bcnt_d = '0;
            if (!dec[4]) begin
              se_d    = 1'b1;
              state_d = HUNT;
              sfd_d   = '0;
            end else if (!half_q) begin
              hi_d   = dec[3:0];
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              if (state_q == LEN) begin
                len_d = pair_byte;
                if (pair_byte == 8'd0) begin
                  fd_d    = 1'b1;
                  state_d = HUNT;
                  sfd_d   = '0;
                end else begin
                  rem_d   = pair_byte;
                  state_d = DATA;
                end
              end else begin
                dout_d = pair_byte;
                dv_d   = 1'b1;
                rem_d  = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
                  fd_d    = 1'b1;
                  state_d = HUNT;
                  sfd_d   = '0;
                end
              end
            end
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          se_d    = 1'b1;
          state_d = HUNT;
          sfd_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        sfd_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sfd_q   <= '0;
      sym_q   <= '0;
      bcnt_q  <= '0;
      half_q  <= 1'b0;
      hi_q    <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      dout_q  <= '0;
      len_q   <= '0;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sfd_q   <= sfd_d;
      sym_q   <= sym_d;
      bcnt_q  <= bcnt_d;
      half_q  <= half_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      len_q   <= len_d;
      dv_q    <= dv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

  assign bus.data_out    = dout_q;
  assign bus.data_valid  = dv_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_len   = len_q;
  assign bus.frame_done  = fd_q;
  assign bus.sym_err     = se_q;
  assign bus.busy        = (state_q != HUNT);

endmodule

// File: tb/tb_vlc_4b6b_rx.sv
// Self-checking bench for vlc_4b6b_rx: per-cycle comparison against a
// bit-queue reference model, a table of length-field vectors, directed
// corner sequences and randomized frames.
module tb_vlc_4b6b_rx;

  localparam int unsigned TIMEOUT = 1024;
  localparam logic [11:0] SFD     = 12'b111000111000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vlc_4b6b_rx_if bus();

  vlc_4b6b_rx #(.SFD_W(12), .SFD(SFD), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] code_tab [16] = '{
    6'b001110, 6'b001101, 6'b010011, 6'b010110,
    6'b010101, 6'b100011, 6'b100110, 6'b100101,
    6'b011001, 6'b011010, 6'b011100, 6'b110001,
    6'b110010, 6'b101001, 6'b101010, 6'b101100
  };

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the receiver described as bit queues.
  bit         m_hunt[$];
  bit         m_fbits[$];
  bit         m_in_frame;
  int         m_rem;
  int         m_idle;
  logic [7:0] e_dout, e_len;
  logic       e_dv, e_fs, e_fd, e_se;

  function automatic int nib_of(input logic [5:0] s);
    for (int i = 0; i < 16; i++) if (code_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [5:0] fsym(input int start);
    logic [5:0] s = '0;
    for (int i = 0; i < 6; i++) s = {s[4:0], logic'(m_fbits[start + i])};
    return s;
  endfunction

  function automatic void m_clear_hunt();
    m_hunt.delete();
    for (int i = 0; i < 12; i++) m_hunt.push_back(1'b0);
  endfunction

  function automatic void m_end_frame();
    m_in_frame = 1'b0;
    m_idle     = 0;
    m_clear_hunt();
  endfunction

  function automatic void model_step(input logic r, input logic bv, input logic bi);
    logic [11:0] w;
    int          n, hi, lo;
    logic [7:0]  b;
    e_dv = 0; e_fs = 0; e_fd = 0; e_se = 0;
    if (r) begin
      e_dout = '0; e_len = '0; m_rem = 0;
      m_end_frame();
      return;
    end
    if (!m_in_frame) begin
      m_idle = 0;
      if (bv) begin
        m_hunt.push_back(bi);
        void'(m_hunt.pop_front());
        w = '0;
        for (int i = 0; i < 12; i++) w = {w[10:0], logic'(m_hunt[i])};
        if (w == SFD) begin
          e_fs = 1;
          m_in_frame = 1;
          m_fbits.delete();
        end
      end
    end else if (bv) begin
      m_idle = 0;
      m_fbits.push_back(bi);
      n = m_fbits.size();
      if (n % 6 == 0) begin
        if (nib_of(fsym(n - 6)) < 0) begin
          e_se = 1;
          m_end_frame();
        end else if (n % 12 == 0) begin
          hi = nib_of(fsym(n - 12));
          lo = nib_of(fsym(n - 6));
          b  = 8'(hi * 16 + lo);
          if (n == 12) begin
            e_len = b;
            m_rem = b;
            if (b == 0) begin
              e_fd = 1;
              m_end_frame();
            end
          end else begin
            e_dout = b;
            e_dv   = 1;
            m_rem--;
            if (m_rem == 0) begin
              e_fd = 1;
              m_end_frame();
            end
          end
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        e_se = 1;
        m_end_frame();
      end
    end
  endfunction

  // Observed pulse bookkeeping for the directed sequences.
  int         o_fs, o_dv, o_fd, o_se, o_coinc, se_at, since_bv;
  logic [7:0] o_bytes[$];

  task automatic clear_obs();
    o_fs = 0; o_dv = 0; o_fd = 0; o_se = 0; o_coinc = 0; se_at = -1;
    o_bytes.delete();
  endtask

  task automatic tick(input logic bv, input logic bi);
    bus.bit_valid = bv;
    bus.bit_in    = bi;
    @(posedge clk);
    model_step(rst, bv, bi);
    if (bv) since_bv = 0; else since_bv++;
    #1;
    check("data_out",    32'(bus.data_out),    32'(e_dout));
    check("data_valid",  32'(bus.data_valid),  32'(e_dv));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
    check("frame_len",   32'(bus.frame_len),   32'(e_len));
    check("frame_done",  32'(bus.frame_done),  32'(e_fd));
    check("sym_err",     32'(bus.sym_err),     32'(e_se));
    check("busy",        32'(bus.busy),        32'(m_in_frame));
    if (bus.frame_start === 1'b1) o_fs++;
    if (bus.data_valid === 1'b1) begin
      o_dv++;
      o_bytes.push_back(bus.data_out);
      if (bus.frame_done === 1'b1) o_coinc++;
    end
    if (bus.frame_done === 1'b1) o_fd++;
    if (bus.sym_err === 1'b1) begin
      o_se++;
      se_at = since_bv;
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int gap);
    int g;
    for (int i = n - 1; i >= 0; i--) begin
      tick(1'b1, v[i]);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) tick(1'b0, 1'b0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    send_bits({52'd0, code_tab[b[7:4]], code_tab[b[3:0]]}, 12, gap);
  endtask

  task automatic send_sfd(input int gap);
    send_bits({52'd0, SFD}, 12, gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    clear_obs();
  endtask

  typedef struct {
    logic [11:0] syms;
    logic [7:0]  exp_len;
    int          exp_se;
    int          exp_fd;
    int          exp_busy;
  } vec_t;

  vec_t vt[7];

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    since_bv      = 0;
    e_dout = '0; e_len = '0; m_rem = 0;
    m_end_frame();
    clear_obs();

    vt[0] = '{12'b001110_001110, 8'h00, 0, 1, 0};
    vt[1] = '{12'b001101_001110, 8'h10, 0, 0, 1};
    vt[2] = '{12'b101100_101100, 8'hFF, 0, 0, 1};
    vt[3] = '{12'b001110_111111, 8'h00, 1, 0, 0};
    vt[4] = '{12'b111000_001110, 8'h00, 1, 0, 0};
    vt[5] = '{12'b010011_010110, 8'h23, 0, 0, 1};
    vt[6] = '{12'b000000_001110, 8'h00, 1, 0, 0};

    // Reset state.
    rst = 1'b1;
    repeat (2) tick(1'b1, 1'b1);
    rst = 1'b0;
    check("rst_busy",     32'(bus.busy),       32'd0);
    check("rst_frame_len", 32'(bus.frame_len), 32'd0);
    check("rst_data_out", 32'(bus.data_out),   32'd0);
    clear_obs();

    // Length-field table.
    foreach (vt[k]) begin
      do_reset();
      send_sfd(0);
      send_bits({52'd0, vt[k].syms}, 12, 1);
      repeat (2) tick(1'b0, 1'b0);
      check($sformatf("vec%0d_fs", k),   32'(o_fs), 32'd1);
      check($sformatf("vec%0d_len", k),  32'(bus.frame_len), 32'(vt[k].exp_len));
      check($sformatf("vec%0d_se", k),   32'(o_se), 32'(vt[k].exp_se));
      check($sformatf("vec%0d_fd", k),   32'(o_fd), 32'(vt[k].exp_fd));
      check($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(vt[k].exp_busy));
      check($sformatf("vec%0d_dv", k),   32'(o_dv), 32'd0);
    end

    // Clean frame, one bit every 4 clocks.
    do_reset();
    send_sfd(3); send_byte(8'h02, 3); send_byte(8'hA5, 3); send_byte(8'h3C, 3);
    check("clean_fs", 32'(o_fs), 32'd1);
    check("clean_len", 32'(bus.frame_len), 32'h02);
    check("clean_dv", 32'(o_dv), 32'd2);
    if (o_bytes.size() == 2) begin
      check("clean_b0", 32'(o_bytes[0]), 32'hA5);
      check("clean_b1", 32'(o_bytes[1]), 32'h3C);
    end
    check("clean_fd_coinc", 32'(o_coinc), 32'd1);
    check("clean_se", 32'(o_se), 32'd0);

    // Zero length.
    clear_obs();
    send_sfd(0); send_bits(64'b001110_001110, 12, 0); tick(1'b0, 1'b0);
    check("zero_fd", 32'(o_fd), 32'd1);
    check("zero_dv", 32'(o_dv), 32'd0);
    check("zero_len", 32'(bus.frame_len), 32'h00);
    check("zero_busy", 32'(bus.busy), 32'd0);

    // Invalid codeword mid-payload, then a clean frame.
    clear_obs();
    send_sfd(1); send_byte(8'h03, 1); send_byte(8'h11, 1); send_bits(64'b111111, 6, 1);
    check("inv_dv", 32'(o_dv), 32'd1);
    if (o_bytes.size() == 1) check("inv_b0", 32'(o_bytes[0]), 32'h11);
    check("inv_se", 32'(o_se), 32'd1);
    check("inv_fd", 32'(o_fd), 32'd0);
    check("inv_busy", 32'(bus.busy), 32'd0);
    clear_obs();
    send_sfd(2); send_byte(8'h01, 2); send_byte(8'h7E, 2);
    check("after_inv_byte", 32'(bus.data_out), 32'h7E);
    check("after_inv_fd", 32'(o_fd), 32'd1);

    // False start: leading 1s before the SFD must not shift the alignment.
    clear_obs();
    send_bits(64'b111, 3, 0); send_sfd(0); send_byte(8'h01, 0); send_byte(8'hFF, 0);
    tick(1'b0, 1'b0);
    check("false_fs", 32'(o_fs), 32'd1);
    check("false_byte", 32'(bus.data_out), 32'hFF);
    check("false_fd", 32'(o_fd), 32'd1);

    // Triple SFD stream: alignment is taken at the first full match, so the
    // third group is decoded as an invalid length symbol.
    clear_obs();
    send_bits(64'b111000111000111000, 18, 0); send_byte(8'h01, 0); send_byte(8'hFF, 0);
    tick(1'b0, 1'b0);
    check("overlap_fs", 32'(o_fs), 32'd1);
    check("overlap_se", 32'(o_se), 32'd1);
    check("overlap_dv", 32'(o_dv), 32'd0);

    // Bit timeout.
    do_reset();
    send_sfd(0); send_byte(8'h04, 0); send_byte(8'h5A, 0);
    check("tmo_byte", 32'(bus.data_out), 32'h5A);
    clear_obs();
    repeat (TIMEOUT + 5) tick(1'b0, 1'b0);
    check("tmo_se", 32'(o_se), 32'd1);
    check("tmo_at", 32'(se_at), 32'(TIMEOUT));
    check("tmo_busy", 32'(bus.busy), 32'd0);

    // Back-to-back bits, then reset mid-frame with bit_valid still high.
    do_reset();
    send_sfd(0); send_byte(8'h05, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    check("b2b_dv", 32'(o_dv), 32'd2);
    rst = 1'b1;
    clear_obs();
    tick(1'b1, 1'b0);
    rst = 1'b0;
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_len", 32'(bus.frame_len), 32'd0);
    check("rstmid_dout", 32'(bus.data_out), 32'd0);
    check("rstmid_pulses", 32'(o_dv + o_fd + o_se + o_fs), 32'd0);
    send_sfd(0); tick(1'b0, 1'b0);
    check("rstmid_sfd", 32'(o_fs), 32'd1);

    // Randomized frames against the model.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int nlen;
      logic [63:0] noise;
      noise = {$urandom, $urandom};
      send_bits(noise, int'($urandom_range(0, 20)), -1);
      send_sfd(-1);
      nlen = int'($urandom_range(0, 4));
      send_byte(8'(nlen), -1);
      for (int b = 0; b < nlen; b++) begin
        if ($urandom_range(0, 9) == 0) begin
          send_bits(64'b111111, 6, -1);
          break;
        end
        send_byte(8'($urandom), -1);
      end
      repeat (int'($urandom_range(0, 5))) tick(1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
